// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch queue.
// Revision    : 1.0
// ============================================================================
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_WAIT         = 2'd1,
        ST_WAIT_DISCARD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] INST_NOP         = 32'hffff_ffff;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous FIFO of {pc, inst} pairs; clear beats push/pop.
// Revision    : 1.0
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_clear,
    input  logic [63:0]            i_data,
    output logic [$clog2(DEPTH):0] o_count,
    output logic [63:0]            o_head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    logic [63:0]   r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic w_push;
    logic w_pop;

    assign w_push = i_push && !i_clear;
    assign w_pop  = i_pop && !i_clear && (r_count != '0);

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: an empty FIFO presents the NOP pattern instead.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push && !i_pop) begin
            assert (r_count != C_DEPTH);
        end
    end

    assign o_count = r_count;
    assign o_head  = (r_count == '0) ? {INST_NOP, INST_NOP} : r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_queue
// Description : Sequential fetch with single outstanding request, jump flush
//               and a decode-side FIFO of {pc, inst}.
// Revision    : 1.0
// ============================================================================
module inst_fetch_queue
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        inst_start,
    input  logic        inst_ready,
    output logic [31:0] i_addr,
    input  logic [31:0] inst,
    input  logic        inst_valid,
    input  logic        jump_valid,
    input  logic [31:0] jump_addr,
    input  logic        halt,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    fetch_state_t  r_state;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_req_pc;

    logic [CW-1:0] w_count;
    logic [63:0]   w_head;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;

    assign inst_start = !reset && (r_state == ST_IDLE) && inst_ready && !halt
                        && !jump_valid && (w_count < C_DEPTH);
    assign w_accept   = inst_start && inst_ready;

    // A response coinciding with a jump belongs to the old stream: drop it.
    assign w_push     = (r_state == ST_WAIT) && inst_valid && !jump_valid;
    assign id_valid   = (w_count != '0) && !jump_valid;
    assign w_pop      = id_valid && id_ready;

    assign i_addr     = r_fetch_pc;
    assign id_pc      = w_head[63:32];
    assign id_inst    = w_head[31:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= RESET_PC;
        end else begin
            if (jump_valid) begin
                r_fetch_pc <= jump_addr;
            end else if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_accept) begin
                r_req_pc <= r_fetch_pc;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (inst_valid) begin
                        r_state <= ST_IDLE;
                    end else if (jump_valid) begin
                        r_state <= ST_WAIT_DISCARD;
                    end
                end
                ST_WAIT_DISCARD: begin
                    if (inst_valid) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (jump_valid),
        .i_data  ({r_req_pc, inst}),
        .o_count (w_count),
        .o_head  (w_head)
    );

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch_queue
// Description : Randomized scoreboard bench for inst_fetch_queue.
// Revision    : 1.0
// ============================================================================
module tb_inst_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic        inst_ready = 1'b0;
    logic        inst_valid = 1'b0;
    logic [31:0] inst       = 32'h0;
    logic        jump_valid = 1'b0;
    logic [31:0] jump_addr  = 32'h0;
    logic        halt       = 1'b0;
    logic        id_ready   = 1'b0;
    logic        inst_start;
    logic        id_valid;
    logic [31:0] i_addr;
    logic [31:0] id_pc;
    logic [31:0] id_inst;

    always #5 clk = ~clk;

    inst_fetch_queue #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .inst_start (inst_start),
        .inst_ready (inst_ready),
        .i_addr     (i_addr),
        .inst       (inst),
        .inst_valid (inst_valid),
        .jump_valid (jump_valid),
        .jump_addr  (jump_addr),
        .halt       (halt),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_pc      (id_pc),
        .id_inst    (id_inst)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected fetch stream and decode queue contents.
    logic [31:0] m_next_pc = RESET_PC;
    logic [31:0] m_req_pc  = RESET_PC;
    bit          m_out     = 1'b0;
    bit          m_drop    = 1'b0;
    bit          prev_reset = 1'b1;
    logic [63:0] m_q[$];

    // Accepts observed on the bus, handed to the memory responder.
    int          acc_cnt  = 0;
    logic [31:0] acc_addr = 32'h0;

    always @(negedge clk) begin
        bit exp_start;
        bit exp_idv;
        if (reset) begin
            chk("rst_inst_start", {63'h0, inst_start}, 64'h0);
            if (prev_reset) begin
                chk("rst_id_valid", {63'h0, id_valid}, 64'h0);
                chk("rst_i_addr", {32'h0, i_addr}, {32'h0, RESET_PC});
                chk("rst_id_head", {id_pc, id_inst}, {64{1'b1}});
            end
            m_next_pc = RESET_PC;
            m_out     = 1'b0;
            m_drop    = 1'b0;
            m_q.delete();
        end else begin
            exp_start = inst_ready && !halt && !jump_valid && !m_out && (m_q.size() < DEPTH);
            exp_idv   = (m_q.size() != 0) && !jump_valid;
            chk("inst_start", {63'h0, inst_start}, {63'h0, exp_start});
            chk("i_addr", {32'h0, i_addr}, {32'h0, m_next_pc});
            chk("id_valid", {63'h0, id_valid}, {63'h0, exp_idv});
            if (exp_idv) begin
                chk("id_head", {id_pc, id_inst}, m_q[0]);
            end else if (m_q.size() == 0) begin
                chk("id_empty_head", {id_pc, id_inst}, {64{1'b1}});
            end
            if (exp_idv && id_ready) begin
                void'(m_q.pop_front());
            end
            if (inst_valid && m_out) begin
                m_out = 1'b0;
                if (!m_drop && !jump_valid) begin
                    m_q.push_back({m_req_pc, m_req_pc ^ KEY});
                end
            end
            if (exp_start) begin
                m_out     = 1'b1;
                m_drop    = 1'b0;
                m_req_pc  = m_next_pc;
                m_next_pc = m_next_pc + 32'd4;
            end
            if (jump_valid) begin
                m_q.delete();
                m_next_pc = jump_addr;
                if (m_out) begin
                    m_drop = 1'b1;
                end
            end
        end
        if (inst_start && inst_ready) begin
            acc_cnt++;
            acc_addr = i_addr;
        end
        prev_reset = reset;
    end

    // Memory responder state, owned by the stimulus process.
    int          acc_taken = 0;
    bit          pend      = 1'b0;
    int          pend_cnt  = 0;
    logic [31:0] pend_addr = 32'h0;
    int          dmin      = 0;
    int          dmax      = 0;

    task automatic step();
        @(posedge clk);
        #1;
        inst_valid = 1'b0;
        if (acc_cnt != acc_taken) begin
            acc_taken = acc_cnt;
            pend      = 1'b1;
            pend_addr = acc_addr;
            pend_cnt  = $urandom_range(dmax, dmin);
        end
        if (pend) begin
            if (pend_cnt == 0) begin
                inst_valid = 1'b1;
                inst       = pend_addr ^ KEY;
                pend       = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
    endtask

    task automatic wait_outstanding(input string name);
        bit hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (m_out) begin
                hit = 1'b1;
                break;
            end
            step();
        end
        chk(name, {63'h0, hit}, 64'h1);
    endtask

    initial begin
        bit hit;
        repeat (3) step();
        reset      = 1'b0;
        inst_ready = 1'b1;
        id_ready   = 1'b1;
        repeat (20) step();

        // Back-pressure fills the queue, then it drains in order.
        id_ready = 1'b0;
        repeat (16) step();
        id_ready = 1'b1;
        repeat (16) step();

        // Jump while a request is outstanding.
        dmin = 2;
        dmax = 2;
        wait_outstanding("sync_jump_wait");
        jump_valid = 1'b1;
        jump_addr  = 32'h0000_0100;
        step();
        jump_valid = 1'b0;
        repeat (10) step();

        // Jump coinciding with a response.
        dmin = 1;
        dmax = 1;
        hit  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (inst_valid) begin
                jump_valid = 1'b1;
                jump_addr  = 32'h0000_0100;
                hit        = 1'b1;
                break;
            end
        end
        chk("sync_jump_resp", {63'h0, hit}, 64'h1);
        step();
        jump_valid = 1'b0;
        repeat (8) step();

        // Memory not ready, then halt during an outstanding request.
        inst_ready = 1'b0;
        repeat (5) step();
        inst_ready = 1'b1;
        wait_outstanding("sync_halt_wait");
        halt = 1'b1;
        repeat (6) step();
        halt = 1'b0;
        repeat (6) step();

        // Address wrap at the top of the address space.
        dmin = 0;
        dmax = 0;
        step();
        jump_valid = 1'b1;
        jump_addr  = 32'hFFFF_FFFC;
        step();
        jump_valid = 1'b0;
        repeat (10) step();

        // Reset while waiting: the late response must be ignored.
        dmin = 3;
        dmax = 3;
        wait_outstanding("sync_reset_wait");
        reset      = 1'b1;
        inst_ready = 1'b0;
        step();
        reset = 1'b0;
        for (int i = 0; i < 10 && pend; i++) begin
            step();
        end
        step();
        inst_ready = 1'b1;
        repeat (10) step();

        // Randomized traffic.
        dmin = 0;
        dmax = 3;
        for (int i = 0; i < 600; i++) begin
            step();
            inst_ready = ($urandom_range(3, 0) != 0);
            id_ready   = $urandom_range(1, 0) != 0;
            halt       = ($urandom_range(7, 0) == 0);
            jump_valid = ($urandom_range(15, 0) == 0);
            jump_addr  = $urandom;
        end
        jump_valid = 1'b0;
        halt       = 1'b0;
        repeat (10) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Instruction fetch front end that sits directly upstream of the memory interface's instruction port. It generates sequential fetch addresses, issues single-outstanding requests over the `inst_start`/`inst_ready`/`inst_valid` handshake, and buffers returned instructions with their PCs in a small FIFO. Decode consumes from that FIFO through a valid/ready handshake. A jump redirect flushes the queue and discards any in-flight response.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `DEPTH`, 4, FIFO entries; power of two, ≥2
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high
- `inst_start`  out  1  fetch request; only asserted while `inst_ready`=1
- `inst_ready`  in  1  memory interface accepts a request this cycle
- `i_addr`  out  32  fetch address; equals `fetch_pc` at all times
- `inst`  in  32  returned instruction; meaningful only when `inst_valid`=1
- `inst_valid`  in  1  single-cycle response pulse, ≥1 cycle after the accepting cycle
- `jump_valid`  in  1  redirect request from downstream
- `jump_addr`  in  32  redirect target; used as-is, no alignment forcing
- `halt`  in  1  blocks new requests; the outstanding one still completes
- `id_valid`  out  1  head entry available to decode
- `id_ready`  in  1  decode accepts the head entry
- `id_pc`  out  32  PC of the head entry
- `id_inst`  out  32  instruction of the head entry

## Operation
- Accept means `inst_start && inst_ready`.
  - On accept: `fetch_pc += 4` (mod 2^32, wraps silently).
  - `req_pc` latches the accepted address.
- `inst_start = !reset && state==IDLE && inst_ready && !halt && !jump_valid && count < DEPTH`.
- At most one outstanding request at any time.
- FSM:
  - IDLE → WAIT on accept.
  - WAIT → IDLE on `inst_valid`. Push `{req_pc, inst}` into the FIFO.
  - WAIT → WAIT_DISCARD on `jump_valid` without a same-cycle `inst_valid`.
  - WAIT_DISCARD → IDLE on `inst_valid`. The response is dropped.
  - WAIT with `inst_valid` and `jump_valid` in the same cycle → IDLE. The response is dropped.
- Jump (any state):
  - FIFO cleared.
  - `fetch_pc <= jump_addr`.
  - `id_valid` forced to 0 in the jump cycle, so no pop occurs.
- Decode side:
  - `id_valid = count != 0 && !jump_valid`.
  - Pop when `id_valid && id_ready`.
  - Push and pop in the same cycle leave `count` unchanged.
- Overflow cannot occur: a request is issued only when `count < DEPTH`, and only one is outstanding.
  - Push while full is a verification assertion failure.
- `halt`:
  - No new requests are issued.
  - The outstanding response is still pushed.
  - Decode handshake keeps operating.

## Timing
- Reset values:
  - `inst_start`=0, `id_valid`=0.
  - `i_addr`=`RESET_PC`, `id_pc`/`id_inst`=32'hffff_ffff.
  - state=IDLE, `count`=0.
  - Reset mid-request: the in-flight response after reset is ignored, because state is IDLE.
- First `inst_start`: the first cycle with `reset`=0, given `inst_ready`=1.
- Response to `id_valid`:
  - Push on the `inst_valid` cycle.
  - `id_valid` rises on the next edge (registered FIFO).
  - Minimum request-to-decode latency is 2 cycles after accept.
- Throughput: at most 1 instruction per 2 cycles, bounded by the single outstanding request.
- After a jump, `inst_start` may assert the next cycle at `jump_addr`, but only if state is IDLE. Otherwise it waits for the discarded response.
- `id_pc`/`id_inst` are stable while `id_valid`=1 and `id_ready`=0.
- Both read 32'hffff_ffff when the FIFO is empty.

## Structure
- Shared package `fetch_pkg`:
  - FSM state encoding (IDLE/WAIT/WAIT_DISCARD, 2 bits).
  - `INST_NOP` = 32'hffff_ffff.
  - Default `RESET_PC`.
- Sub-module `fetch_fifo`:
  - Synchronous FIFO, 64-bit entries `{pc, inst}`, depth `DEPTH`.
  - Ports: push, pop, clear, `count`, head data.
  - `clear` has priority over push and pop.

## Test plan
- Reset release, `inst_ready`=1, memory answers 1 cycle after accept with `inst` = addr^32'hA5A5_0000, `id_ready`=1:
  - Requests appear at 0x0, 0x4, 0x8.
  - `id_pc`/`id_inst` are 0x0/0xA5A5_0000, then 0x4/0xA5A5_0004, and so on, in order.
- `id_ready`=0 with `DEPTH`=4:
  - Exactly 4 requests issue, then `inst_start` stays 0.
  - Raising `id_ready` drains 0x0..0xC, then fetching resumes at 0x10.
- `jump_valid` with `jump_addr`=0x100 while in WAIT:
  - The response to 0x8 is dropped and the FIFO is empty.
  - The next request is 0x100 in the cycle after that response arrives.
- `jump_valid` in the same cycle as `inst_valid`:
  - No push occurs and `id_valid`=0 that cycle.
  - The next cycle `inst_start`=1 with `i_addr`=0x100.
- `inst_ready` held low for 5 cycles, and `halt`=1 asserted during WAIT:
  - No requests issue during either condition.
  - The pending response is still delivered to decode.
- `fetch_pc`=0xFFFF_FFFC: the request is accepted and the next address is 0x0000_0000.
- `reset` asserted in WAIT: the late `inst_valid` produces no push, and fetch restarts at `RESET_PC`.
